// File: rtl/pio_strobe_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : pio_strobe_rx_fifo_if
// Purpose  : Groups the external strobe/ack data bus and the Avalon-MM slave
//            register bus of the PIO receive FIFO into one bundle.
// Ports    : none (interface signals only)
//   bus_data    - external parallel data, stable while bus_strobe is high
//   bus_strobe  - asynchronous producer strobe
//   bus_ack     - registered acknowledge back to the producer
//   address     - Avalon register select (2 bits)
//   chipselect  - Avalon select
//   read        - Avalon read strobe
//   write_n     - Avalon write, active low
//   writedata   - Avalon write data
//   readdata    - registered Avalon read data
//   irq         - level interrupt
// Modports : master (producer + CPU side), slave (the FIFO block)
// Revision : 1.0 - initial release
// ============================================================================
interface pio_strobe_rx_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] bus_data;
  logic              bus_strobe;
  logic              bus_ack;
  logic [1:0]        address;
  logic              chipselect;
  logic              read;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output bus_data,
    output bus_strobe,
    input  bus_ack,
    output address,
    output chipselect,
    output read,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  bus_data,
    input  bus_strobe,
    output bus_ack,
    input  address,
    input  chipselect,
    input  read,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface
`default_nettype wire

// File: rtl/pio_strobe_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pio_strobe_rx_fifo
// Purpose  : Receive stage for the 32-bit bidirectional data PIO. Words are
//            taken from the external parallel bus with a four-phase
//            strobe/ack handshake, buffered in a FIFO and drained by the CPU
//            through an Avalon-MM slave. An interrupt is raised when the fill
//            level reaches a programmable threshold.
// Ports    :
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - pio_strobe_rx_fifo_if.slave (external bus + Avalon slave + irq)
// Registers:
//   0 R  : FIFO head (read pops; empty read returns 0 and flags underflow)
//   1 RW : status {count[23:16], underflow[3], irq_pend[2], full[1], empty[0]}
//          write bit3=1 clears underflow
//   2 RW : ctrl {flush[2] (self-clearing), irq_en[1], enable[0]}
//   3 RW : thresh (clog2(DEPTH)+1 bits)
// Revision : 1.0 - initial release
// ============================================================================
module pio_strobe_rx_fifo #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_strobe_rx_fifo_if.slave  bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Strobe synchronizer
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_strobe_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.bus_strobe};
    end
  end

  assign w_strobe_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Storage and control state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_enable;
  logic               r_irq_en;
  logic [c_cnt_w-1:0] r_thresh;
  logic               r_underflow;
  logic [DATA_W-1:0]  r_readdata;
  logic               r_irq;
  logic               r_ack;
  state_t             r_state;
  state_t             w_state_nxt;

  logic w_empty;
  logic w_full;
  logic w_irq_pend;
  logic w_wr;
  logic w_rd_fifo;
  logic w_pop;
  logic w_underflow_set;
  logic w_flush;
  logic w_accept;
  logic w_push;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_full_count);
  assign w_irq_pend = (r_count >= r_thresh) && (r_thresh != '0);

  // --------------------------------------------------------------------------
  // Avalon decode
  // --------------------------------------------------------------------------
  assign w_wr            = bus.chipselect & ~bus.write_n;
  assign w_rd_fifo       = bus.chipselect & bus.read & (bus.address == 2'd0);
  assign w_pop           = w_rd_fifo & ~w_empty;
  assign w_underflow_set = w_rd_fifo & w_empty;
  assign w_flush         = w_wr & (bus.address == 2'd2) & bus.writedata[2];

  // A word accepted in the same cycle as a flush is dropped from storage;
  // the handshake still completes because the FSM only sees w_accept.
  assign w_push = w_accept & ~w_flush;

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == ST_WAIT_LOW);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        if (r_enable && w_strobe_s && (!w_full || w_pop)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        // Enable is deliberately ignored here so a started handshake finishes.
        if (!w_strobe_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and fill count
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.bus_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_thresh    <= c_cnt_w'(1);
      r_underflow <= 1'b0;
    end else begin
      if (w_wr && (bus.address == 2'd2)) begin
        r_enable <= bus.writedata[0];
        r_irq_en <= bus.writedata[1];
      end
      if (w_wr && (bus.address == 2'd3)) begin
        r_thresh <= bus.writedata[c_cnt_w-1:0];
      end
      // A new underflow in the same cycle as a clear wins, so it is not lost.
      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end else if (w_wr && (bus.address == 2'd1) && bus.writedata[3]) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux, registered every cycle
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_mux;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      2'd0: begin
        if (!w_empty) begin
          w_rd_mux = r_mem[r_rd_ptr];
        end
      end
      2'd1: begin
        w_rd_mux[0]             = w_empty;
        w_rd_mux[1]             = w_full;
        w_rd_mux[2]             = w_irq_pend;
        w_rd_mux[3]             = r_underflow;
        w_rd_mux[16 +: c_cnt_w] = r_count;
      end
      2'd2: begin
        w_rd_mux[1:0] = {r_irq_en, r_enable};
      end
      default: begin
        w_rd_mux[c_cnt_w-1:0] = r_thresh;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= w_rd_mux;
      r_irq      <= r_irq_en & w_irq_pend;
    end
  end

  // Only a few write-data bits select register fields.
  logic w_unused_wdata;
  assign w_unused_wdata = ^bus.writedata;

  assign bus.bus_ack  = r_ack;
  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pio_strobe_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_strobe_rx_fifo
// Purpose  : Self-checking bench for pio_strobe_rx_fifo: register table,
//            directed handshake/FIFO corner sequences and a randomized run
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_strobe_rx_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pio_strobe_rx_fifo_if #(.DATA_W(DATA_W)) bus_if ();

  pio_strobe_rx_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_en;
  bit          m_irqen;
  bit          m_under;
  int          m_thresh;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_pend();
    return (m_thresh != 0) && (q.size() >= m_thresh);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (q.size() == 0);
    s[1]     = (q.size() == DEPTH);
    s[2]     = m_pend();
    s[3]     = m_under;
    s[23:16] = 8'(q.size());
    return s;
  endfunction

  task automatic m_reset();
    q.delete();
    m_en     = 1'b0;
    m_irqen  = 1'b0;
    m_under  = 1'b0;
    m_thresh = 1;
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = addr;
    bus_if.writedata  = data;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    case (addr)
      2'd1: if (data[3]) m_under = 1'b0;
      2'd2: begin
        m_en    = data[0];
        m_irqen = data[1];
        if (data[2]) q.delete();
      end
      2'd3: m_thresh = int'(data[4:0]);
      default: ;
    endcase
  endtask

  task automatic cpu_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = addr;
    tick();
    data              = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
  endtask

  task automatic fifo_read(input string name);
    logic [31:0] d;
    logic [31:0] exp;
    if (q.size() == 0) begin
      exp     = '0;
      m_under = 1'b1;
    end else begin
      exp = q.pop_front();
    end
    cpu_read(2'd0, d);
    check(name, d, exp);
  endtask

  task automatic status_check(input string name);
    logic [31:0] d;
    cpu_read(2'd1, d);
    check(name, d, m_status());
  endtask

  // Raise strobe and wait (bounded) for ack; an accepted word enters the model.
  task automatic send_start(input logic [31:0] word, output bit acked);
    bus_if.bus_data   = word;
    bus_if.bus_strobe = 1'b1;
    acked             = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.bus_ack) begin
        acked = 1'b1;
        break;
      end
    end
    if (acked) q.push_back(word);
  endtask

  task automatic send_finish();
    bus_if.bus_strobe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus_if.bus_ack) break;
    end
    check("ack_fall", {31'd0, bus_if.bus_ack}, 32'd0);
  endtask

  task automatic send(input logic [31:0] word);
    bit a;
    send_start(word, a);
    check("ack_rise", {31'd0, a}, 32'd1);
    send_finish();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit          a;
    int          lat;
    int          op;

    vecs[0]  = '{1'b0, 2'd1, 32'h0,        32'h0000_0001};
    vecs[1]  = '{1'b0, 2'd2, 32'h0,        32'h0000_0000};
    vecs[2]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0001};
    vecs[3]  = '{1'b1, 2'd3, 32'h0000_001F, 32'h0};
    vecs[4]  = '{1'b0, 2'd3, 32'h0,        32'h0000_001F};
    vecs[5]  = '{1'b1, 2'd3, 32'hFFFF_FFE5, 32'h0};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,        32'h0000_0005};
    vecs[7]  = '{1'b1, 2'd2, 32'h0000_0007, 32'h0};
    vecs[8]  = '{1'b0, 2'd2, 32'h0,        32'h0000_0003};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0000};
    vecs[10] = '{1'b0, 2'd1, 32'h0,        32'h0000_0009};
    vecs[11] = '{1'b1, 2'd1, 32'h0000_0008, 32'h0};
    vecs[12] = '{1'b0, 2'd1, 32'h0,        32'h0000_0001};
    vecs[13] = '{1'b1, 2'd3, 32'h0000_0001, 32'h0};
    vecs[14] = '{1'b1, 2'd2, 32'h0000_0000, 32'h0};

    bus_if.bus_data   = '0;
    bus_if.bus_strobe = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    reset             = 1'b1;
    m_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_ack", {31'd0, bus_if.bus_ack}, 32'd0);
    check("reset_irq", {31'd0, bus_if.irq}, 32'd0);
    check("reset_readdata", bus_if.readdata, 32'd0);

    // Register table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        reg_write(vecs[i].addr, vecs[i].data);
      end else begin
        cpu_read(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    m_reset();

    // Single word and ack latency
    reg_write(2'd2, 32'h1);
    bus_if.bus_data   = 32'hDEAD_BEEF;
    bus_if.bus_strobe = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (bus_if.bus_ack) break;
    end
    check("ack_latency", lat, 3);
    q.push_back(32'hDEAD_BEEF);
    send_finish();
    status_check("status_one");
    fifo_read("read_deadbeef");
    status_check("status_empty");

    // Fill, back-pressure, then pop with simultaneous push while full
    for (int w = 0; w < DEPTH; w++) send(32'(w));
    status_check("status_full");
    bus_if.bus_data   = 32'h10;
    bus_if.bus_strobe = 1'b1;
    repeat (10) tick();
    check("no_ack_full", {31'd0, bus_if.bus_ack}, 32'd0);
    fifo_read("pop_while_full");
    a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.bus_ack) begin
        a = 1'b1;
        break;
      end
      tick();
    end
    check("ack_after_pop", {31'd0, a}, 32'd1);
    q.push_back(32'h10);
    send_finish();
    status_check("status_full_again");
    for (int i = 0; i < DEPTH; i++) fifo_read($sformatf("drain%0d", i));

    // Threshold interrupt
    reg_write(2'd3, 32'd4);
    reg_write(2'd2, 32'h3);
    for (int i = 0; i < 3; i++) send($urandom);
    tick();
    check("irq_below", {31'd0, bus_if.irq}, 32'd0);
    send_start(32'hA5A5_0004, a);
    check("ack_rise_4th", {31'd0, a}, 32'd1);
    check("irq_lag", {31'd0, bus_if.irq}, 32'd0);
    tick();
    check("irq_at_thresh", {31'd0, bus_if.irq}, 32'd1);
    send_finish();
    fifo_read("pop_irq");
    tick();
    check("irq_after_pop", {31'd0, bus_if.irq}, 32'd0);

    // Flush with five entries
    send($urandom);
    send($urandom);
    status_check("status_five");
    reg_write(2'd2, 32'h7);
    status_check("status_flushed");

    // Disable during WAIT_LOW
    reg_write(2'd2, 32'h1);
    send_start(32'h1234_5678, a);
    check("ack_rise_en", {31'd0, a}, 32'd1);
    reg_write(2'd2, 32'h0);
    check("ack_hold_disabled", {31'd0, bus_if.bus_ack}, 32'd1);
    send_finish();
    bus_if.bus_data   = 32'h8765_4321;
    bus_if.bus_strobe = 1'b1;
    repeat (10) tick();
    check("no_capture_disabled", {31'd0, bus_if.bus_ack}, 32'd0);
    bus_if.bus_strobe = 1'b0;
    repeat (4) tick();
    status_check("status_disabled");

    // Reset while ack is high
    reg_write(2'd2, 32'h1);
    send_start(32'h0BAD_F00D, a);
    check("ack_rise_rst", {31'd0, a}, 32'd1);
    reset = 1'b1;
    tick();
    check("ack_reset", {31'd0, bus_if.bus_ack}, 32'd0);
    reset = 1'b0;
    m_reset();
    status_check("status_after_reset");
    bus_if.bus_strobe = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model
    reg_write(2'd3, 32'($urandom_range(0, 8)));
    reg_write(2'd2, 32'h1 | (32'($urandom_range(0, 1)) << 1));
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        if (q.size() < DEPTH) send($urandom);
        else fifo_read("rand_read_full");
      end else if (op <= 6) begin
        fifo_read("rand_read");
      end else if (op == 7) begin
        status_check("rand_status");
      end else if (op == 8) begin
        reg_write(2'd3, 32'($urandom_range(0, 17)));
      end else if ($urandom_range(0, 7) == 0) begin
        reg_write(2'd2, {29'd0, 1'b1, m_irqen, m_en});
      end else begin
        reg_write(2'd1, 32'h8);
      end
      tick();
      check("rand_irq", {31'd0, bus_if.irq}, {31'd0, m_irqen && m_pend()});
    end
    status_check("rand_final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_strobe_rx_fifo.md
Name: pio_strobe_rx_fifo

Overview:
Receive stage on the external side of the 32-bit bidirectional data PIO. It takes words from the shared parallel data bus with a four-phase strobe/ack handshake and buffers them in a FIFO. The CPU drains them through an Avalon-MM slave, so software does not have to poll the PIO input word by word. An interrupt fires when the buffer fill reaches a programmable level.

Parameters:
DATA_W, 32, width of bus data and FIFO words
DEPTH, 16, FIFO entries; power of two, at least 2
SYNC_STAGES, 2, flip-flop stages on bus_strobe, at least 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
bus_data  in  DATA_W  external parallel data; stable while bus_strobe is high
bus_strobe  in  1  asynchronous producer strobe
bus_ack  out  1  registered handshake acknowledge to producer
address  in  2  Avalon register select
chipselect  in  1  Avalon select
read  in  1  Avalon read strobe
write_n  in  1  Avalon write, active low
writedata  in  DATA_W  Avalon write data
readdata  out  DATA_W  registered Avalon read data
irq  out  1  level interrupt

Behaviour:
- Reset (synchronous): FSM=IDLE, bus_ack=0, FIFO empty, count=0, ctrl=0, thresh=1, underflow=0, readdata=0, irq=0. Synchronizer flops also clear.
- strobe_s is bus_strobe after SYNC_STAGES flops.
- FSM IDLE:
  - If ctrl.enable=1, strobe_s=1 and FIFO not full: push bus_data, then next cycle bus_ack=1 and state becomes WAIT_LOW.
  - If the FIFO is full: stay in IDLE with ack held at 0. This back-pressures the producer; no data is lost and nothing overflows.
- FSM WAIT_LOW: hold bus_ack=1 until strobe_s=0, then bus_ack=0 and state returns to IDLE. Clearing enable in this state does not abort the handshake; it completes normally.
- Latency: bus_ack rises SYNC_STAGES+1 clk cycles after bus_strobe is first sampled high (3 at default).
- Register map:
  - addr0 read: FIFO head. A read with chipselect&read&addr0 and FIFO not empty pops one entry. A read when empty returns 0, does not pop, and sets underflow.
  - addr1 read: status = {.., underflow[3], irq_pend[2], full[1], empty[0]} with count in bits [23:16]. Writing addr1 with bit3=1 clears underflow.
  - addr2 read/write: ctrl. Bit0 enable, bit1 irq_en. Bit2 flush is self-clearing and always reads 0.
  - addr3 read/write: thresh, using clog2(DEPTH)+1 bits.
- Write strobe is chipselect & ~write_n. readdata is registered every cycle from the address mux, giving 1-cycle read latency. Unused bits read 0.
- Simultaneous push and pop: both take effect, count is unchanged. This is legal when full (pop frees a slot in the same cycle, so the push is accepted) and when count=1.
- Flush: empties the FIFO and zeroes pointers and count in the cycle it is written. A push in that same cycle is discarded, but the handshake still completes with ack. Flush has no effect on the FSM.
- Pointers are log2(DEPTH) bits and wrap naturally. count is clog2(DEPTH)+1 bits, range 0..DEPTH.
- irq_pend = (count >= thresh) & (thresh != 0). irq is registered as irq_en & irq_pend, so it has 1 cycle of latency.
- Reset mid-handshake: bus_ack drops the cycle after reset. A producer that still holds strobe high is re-captured as a new word once reset is released.

Test Plan:
- enable=1, producer sends 0xDEADBEEF -> bus_ack rises 3 cycles after strobe. Read addr1 -> count=1, empty=0. Read addr0 -> 0xDEADBEEF, then status shows empty=1.
- Send 16 words 0x0..0xF with no reads -> full=1 after the 16th. A 17th strobe gets no ack. Pop once -> the 17th word is acked, and reading addr0 ×16 returns 0x1..0x10 in order.
- thresh=4, irq_en=1, push 3 words -> irq=0. Push the 4th -> irq=1 one cycle after count reaches 4. Pop once -> irq=0.
- Read addr0 with the FIFO empty -> readdata=0 and underflow=1. Write addr1 bit3 -> underflow=0.
- Full FIFO with a pop and a push acceptance in the same cycle -> count stays 16 and ordering is preserved. Flush with 5 entries -> count=0, empty=1.
- Drop enable while in WAIT_LOW -> ack stays high until strobe falls, then no further words are captured. Assert reset with ack high -> ack=0 next cycle and the FIFO is empty.
